// File: rtl/a_rr_scheduler.sv
// Round-robin scheduler sharing one fixed-latency datapath block a.
// Grants one requester at a time, launches a, times it, returns done.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   req      per-requester request, held until done
//   req_d1   packed operands, requester i in [i*g_w1 +: g_w1]
//   gnt      one-hot grant, held for the whole operation
//   done     one-cycle completion pulse to the granted requester
//   dp_start one-cycle launch strobe to a
//   dp_d1    registered operand of the winner (a.d1)
//   dp_sel   registered winner index (a.b)
module a_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int g_w1    = 8,
    parameter int delay   = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*g_w1-1:0]   req_d1,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic                      dp_start,
    output logic [g_w1-1:0]           dp_d1,
    output logic [3:0]                dp_sel
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = $clog2(delay + 1);
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   idx;
    logic [CW-1:0]   cnt;

    logic [PW-1:0]   win;
    logic            win_ok;
    logic [PW-1:0]   probe;

    // Scan upward from the slot after the last grant, wrapping around,
    // so the most recently served requester has the lowest priority.
    always_comb begin
        win    = '0;
        win_ok = 1'b0;
        probe  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            probe = PW'((int'(ptr) + k) % NUM_REQ);
            if (!win_ok && req[probe]) begin
                win_ok = 1'b1;
                win    = probe;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            done     <= '0;
            dp_start <= 1'b0;
            dp_d1    <= '0;
            dp_sel   <= '0;
            cnt      <= '0;
            idx      <= '0;
            // Pointer starts at the top so requester 0 wins first.
            ptr      <= PW'(NUM_REQ - 1);
        end else begin
            unique case (state)
                IDLE: begin
                    done <= '0;
                    if (win_ok) begin
                        gnt      <= ONE << win;
                        dp_d1    <= req_d1[win*g_w1 +: g_w1];
                        dp_sel   <= 4'(win);
                        idx      <= win;
                        dp_start <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    dp_start <= 1'b0;
                    cnt      <= CW'(delay);
                    state    <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt - CW'(1);
                    // Last wait cycle: raise done so it is visible
                    // exactly in the DONE cycle.
                    if (cnt == CW'(1)) begin
                        done  <= gnt;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= '0;
                    gnt   <= '0;
                    ptr   <= idx;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_a_rr_scheduler.sv
// Scoreboard bench for a_rr_scheduler: delay=5 and delay=1 builds
// driven by the same random stimulus, checked against a timing model.
module tb_a_rr_scheduler;

    localparam int N = 4;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req = '0;
    logic [N*W-1:0] req_d1 = '0;

    logic [N-1:0] gnt [2];
    logic [N-1:0] done [2];
    logic         dps [2];
    logic [W-1:0] dpd [2];
    logic [3:0]   dsel [2];

    always #5 clk = ~clk;

    a_rr_scheduler #(.NUM_REQ(N), .g_w1(W), .delay(5)) u_d5 (
        .clk(clk), .rst_n(rst_n), .req(req), .req_d1(req_d1),
        .gnt(gnt[0]), .done(done[0]), .dp_start(dps[0]),
        .dp_d1(dpd[0]), .dp_sel(dsel[0])
    );

    a_rr_scheduler #(.NUM_REQ(N), .g_w1(W), .delay(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .req(req), .req_d1(req_d1),
        .gnt(gnt[1]), .done(done[1]), .dp_start(dps[1]),
        .dp_d1(dpd[1]), .dp_sel(dsel[1])
    );

    typedef struct {
        int           inst;
        int           s;
        int           d;
        logic [N-1:0] g;
        logic [W-1:0] v;
        logic [3:0]   sel;
    } rec_t;

    rec_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   dly [2] = '{5, 1};
    int   free_at [2];
    int   ptr [2];

    rec_t         act [2];
    bit           act_v [2];
    logic [W-1:0] hd1 [2];
    logic [3:0]   hsel [2];

    task automatic chk(input string nm, input int i,
                       input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s inst%0d cyc=%0d got=%0h exp=%0h",
                     nm, i, cyc, a, e);
        end
    endtask

    function automatic int find(input int i);
        foreach (sb[k])
            if (sb[k].inst == i) return k;
        return -1;
    endfunction

    // Reference model: a scheduler is free to pick when the cycle
    // count reaches its free time; each operation occupies delay+3.
    always @(posedge clk) begin
        int w;
        int j;
        rec_t r;
        logic [N-1:0] one;
        one = 1;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                free_at[i] = 0;
                ptr[i] = N - 1;
            end else if (cyc >= free_at[i] && req != 0) begin
                w = -1;
                for (int k = 1; k <= N; k++) begin
                    j = (ptr[i] + k) % N;
                    if (w < 0 && req[j]) w = j;
                end
                r.inst = i;
                r.s = cyc + 1;
                r.d = cyc + 2 + dly[i];
                r.g = one << w;
                r.v = req_d1[w*W +: W];
                r.sel = 4'(w);
                sb.push_back(r);
                ptr[i] = w;
                free_at[i] = cyc + dly[i] + 3;
            end
        end
        if (!rst_n) sb.delete();
        cyc = cyc + 1;
    end

    // Monitor: pops the expected record on every launch strobe.
    always @(negedge clk) begin
        int fi;
        logic [N-1:0] eg;
        logic [N-1:0] ed;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                chk("rst_gnt", i, 32'(gnt[i]), 0);
                chk("rst_done", i, 32'(done[i]), 0);
                chk("rst_start", i, 32'(dps[i]), 0);
                chk("rst_d1", i, 32'(dpd[i]), 0);
                chk("rst_sel", i, 32'(dsel[i]), 0);
                act_v[i] = 0;
                hd1[i] = '0;
                hsel[i] = '0;
            end else begin
                fi = find(i);
                if (dps[i]) begin
                    if (fi < 0) begin
                        chk("spurious_start", i, 1, 0);
                    end else begin
                        act[i] = sb[fi];
                        sb.delete(fi);
                        chk("start_cyc", i, act[i].s, cyc);
                        chk("start_d1", i, 32'(dpd[i]), 32'(act[i].v));
                        chk("start_sel", i, 32'(dsel[i]), 32'(act[i].sel));
                        act_v[i] = 1;
                        hd1[i] = act[i].v;
                        hsel[i] = act[i].sel;
                    end
                end else if (fi >= 0) begin
                    checks++;
                    if (sb[fi].s <= cyc) begin
                        errors++;
                        $display("FAIL missing_start inst%0d cyc=%0d got=0 exp=start",
                                 i, cyc);
                        sb.delete(fi);
                    end
                end
                eg = (act_v[i] && cyc <= act[i].d) ? act[i].g : '0;
                ed = (act_v[i] && cyc == act[i].d) ? act[i].g : '0;
                chk("gnt", i, 32'(gnt[i]), 32'(eg));
                chk("gnt_onehot0", i, 32'($onehot0(gnt[i])), 1);
                chk("done", i, 32'(done[i]), 32'(ed));
                chk("hold_d1", i, 32'(dpd[i]), 32'(hd1[i]));
                chk("hold_sel", i, 32'(dsel[i]), 32'(hsel[i]));
                if (act_v[i] && cyc >= act[i].d) act_v[i] = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_d1();
        for (int i = 0; i < N; i++) req_d1[i*W +: W] = 8'($urandom);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        // all requesters held: strict rotation
        tick();
        req = 4'b1111;
        repeat (45) begin
            rnd_d1();
            tick();
        end
        req = '0;
        repeat (10) tick();

        // single requester with known operand
        req = 4'b0100;
        req_d1[2*W +: W] = 8'hA5;
        repeat (9) tick();
        req = '0;
        repeat (4) tick();

        // request dropped mid-operation
        req = 4'b0100;
        repeat (3) tick();
        req = '0;
        repeat (12) tick();

        // reset in the middle of an operation
        req = 4'b1111;
        repeat (4) tick();
        rst_n = 1'b0;
        repeat (2) tick();
        #2 rst_n = 1'b1;
        repeat (20) tick();

        // pointer wrap between 3 and 0
        req = '0;
        repeat (10) tick();
        req = 4'b1001;
        repeat (30) tick();

        // random traffic
        repeat (300) begin
            req = 4'($urandom);
            rnd_d1();
            tick();
        end
        req = '0;
        repeat (20) tick();

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d exp=0 pending", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
